// File: rtl/reservation_station.sv
// ---------------------------------------------------------------------------
// reservation_station
//
// Buffers ALU-class instructions (LUI/AUIPC/JAL/JALR/RC/RI/BR) handed over by
// the decoder. Operands that are still pending on a ROB tag are woken by
// snooping the ALU and LSB result broadcasts. Each cycle, one
// operand-complete entry is dispatched to the ALU. rs_full is fed back to the
// decoder stall logic.
//
// Optional build macro: RS_WAKEUP_BYPASS_EN
//   When this macro is defined, an entry whose pending operands are all being
//   broadcast in the current cycle may be selected in that same cycle. The
//   forwarded broadcast values go directly into the dispatch register.
//
// Ports
//   clk_in, rst_n_in          clock, asynchronous active-low reset
//   rdy_in                    global ready; low freezes all state
//   clr_in                    synchronous mispredict flush
//   issue_*                   decoder issue interface (depend == 0 -> value valid)
//   alu_* / lsb_*             result broadcast buses (tag 0 never matches)
//   rs_full                   no free entry, from registered occupancy only
//   rs_to_alu_*               registered dispatch interface to the ALU
// ---------------------------------------------------------------------------
module reservation_station #(
    parameter int RS_SIZE   = 16,
    parameter int ROB_IDX_W = 4,
    parameter int OPENUM_W  = 6
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 rdy_in,
    input  logic                 clr_in,
    input  logic                 issue_rs_ready,
    input  logic [ROB_IDX_W-1:0] issue_rob_index,
    input  logic [OPENUM_W-1:0]  issue_op,
    input  logic [31:0]          issue_rs1_val,
    input  logic [31:0]          issue_rs2_val,
    input  logic [ROB_IDX_W-1:0] issue_rs1_depend,
    input  logic [ROB_IDX_W-1:0] issue_rs2_depend,
    input  logic [31:0]          issue_imm,
    input  logic [31:0]          issue_PC,
    input  logic                 issue_pred_br,
    input  logic                 alu_ready,
    input  logic [ROB_IDX_W-1:0] alu_rob_index,
    input  logic [31:0]          alu_result,
    input  logic                 lsb_ready,
    input  logic [ROB_IDX_W-1:0] lsb_rob_index,
    input  logic [31:0]          lsb_result,
    output logic                 rs_full,
    output logic                 rs_to_alu_valid,
    output logic [OPENUM_W-1:0]  rs_to_alu_op,
    output logic [31:0]          rs_to_alu_rs1_val,
    output logic [31:0]          rs_to_alu_rs2_val,
    output logic [31:0]          rs_to_alu_imm,
    output logic [31:0]          rs_to_alu_PC,
    output logic [ROB_IDX_W-1:0] rs_to_alu_rob_index,
    output logic                 rs_to_alu_pred_br
);
    localparam int IDX_W = $clog2(RS_SIZE);

    // Entry storage
    logic [RS_SIZE-1:0]   busy_q, busy_d;
    logic [OPENUM_W-1:0]  op_q   [RS_SIZE];
    logic [31:0]          v1_q   [RS_SIZE];
    logic [31:0]          v2_q   [RS_SIZE];
    logic [ROB_IDX_W-1:0] q1_q   [RS_SIZE];
    logic [ROB_IDX_W-1:0] q2_q   [RS_SIZE];
    logic [31:0]          imm_q  [RS_SIZE];
    logic [31:0]          pc_q   [RS_SIZE];
    logic [ROB_IDX_W-1:0] rob_q  [RS_SIZE];
    logic                 pred_q [RS_SIZE];

    // Operand fields after this cycle's broadcasts are applied
    logic [31:0]          v1_w [RS_SIZE];
    logic [31:0]          v2_w [RS_SIZE];
    logic [ROB_IDX_W-1:0] q1_w [RS_SIZE];
    logic [ROB_IDX_W-1:0] q2_w [RS_SIZE];
    logic [31:0]          iss_v1_w, iss_v2_w;
    logic [ROB_IDX_W-1:0] iss_q1_w, iss_q2_w;

    logic                 do_issue;
    logic [IDX_W-1:0]     free_idx;
    logic [IDX_W-1:0]     sel_idx;
    logic                 sel_found;

    // Dispatch register
    logic                 valid_q;
    logic [OPENUM_W-1:0]  out_op_q;
    logic [31:0]          out_v1_q, out_v2_q, out_imm_q, out_pc_q;
    logic [ROB_IDX_W-1:0] out_rob_q;
    logic                 out_pred_q;

    // A pending tag matches a valid bus. A tag of 0 never matches because it
    // means that there is no dependency.
    function automatic logic bus_hit(input logic [ROB_IDX_W-1:0] q,
                                     input logic                 bus_vld,
                                     input logic [ROB_IDX_W-1:0] bus_tag);
        return bus_vld && (q != '0) && (q == bus_tag);
    endfunction

    // Wakeup for the stored entries and for the incoming issue. When both
    // buses carry the same tag, the ALU bus takes priority.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            v1_w[i] = v1_q[i];
            q1_w[i] = q1_q[i];
            v2_w[i] = v2_q[i];
            q2_w[i] = q2_q[i];
            if (bus_hit(q1_q[i], alu_ready, alu_rob_index)) begin
                v1_w[i] = alu_result;
                q1_w[i] = '0;
            end else if (bus_hit(q1_q[i], lsb_ready, lsb_rob_index)) begin
                v1_w[i] = lsb_result;
                q1_w[i] = '0;
            end
            if (bus_hit(q2_q[i], alu_ready, alu_rob_index)) begin
                v2_w[i] = alu_result;
                q2_w[i] = '0;
            end else if (bus_hit(q2_q[i], lsb_ready, lsb_rob_index)) begin
                v2_w[i] = lsb_result;
                q2_w[i] = '0;
            end
        end

        iss_v1_w = issue_rs1_val;
        iss_q1_w = issue_rs1_depend;
        iss_v2_w = issue_rs2_val;
        iss_q2_w = issue_rs2_depend;
        if (bus_hit(issue_rs1_depend, alu_ready, alu_rob_index)) begin
            iss_v1_w = alu_result;
            iss_q1_w = '0;
        end else if (bus_hit(issue_rs1_depend, lsb_ready, lsb_rob_index)) begin
            iss_v1_w = lsb_result;
            iss_q1_w = '0;
        end
        if (bus_hit(issue_rs2_depend, alu_ready, alu_rob_index)) begin
            iss_v2_w = alu_result;
            iss_q2_w = '0;
        end else if (bus_hit(issue_rs2_depend, lsb_ready, lsb_rob_index)) begin
            iss_v2_w = lsb_result;
            iss_q2_w = '0;
        end
    end

    // Free-slot and select priority encoders work from the registered busy
    // bits. As a result, a slot freed by dispatch is not reused until the next
    // cycle, and the entry that is being issued can never be selected.
    // Scanning from the top down leaves the lowest index in the result.
    always_comb begin
        free_idx  = '0;
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_idx = IDX_W'(i);
            end
`ifdef RS_WAKEUP_BYPASS_EN
            if (busy_q[i] && (q1_w[i] == '0) && (q2_w[i] == '0)) begin
`else
            if (busy_q[i] && (q1_q[i] == '0) && (q2_q[i] == '0)) begin
`endif
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    assign rs_full  = &busy_q;
    assign do_issue = issue_rs_ready && !rs_full;

    always_comb begin
        busy_d = busy_q;
        if (sel_found) begin
            busy_d[sel_idx] = 1'b0;
        end
        if (do_issue) begin
            busy_d[free_idx] = 1'b1;
        end
    end

    // Control state and dispatch register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy_q     <= '0;
            valid_q    <= 1'b0;
            out_op_q   <= '0;
            out_v1_q   <= '0;
            out_v2_q   <= '0;
            out_imm_q  <= '0;
            out_pc_q   <= '0;
            out_rob_q  <= '0;
            out_pred_q <= 1'b0;
        end else if (clr_in) begin
            busy_q  <= '0;
            valid_q <= 1'b0;
        end else if (rdy_in) begin
            busy_q  <= busy_d;
            valid_q <= sel_found;
            if (sel_found) begin
                // Use the woken values so that the bypass build forwards the
                // broadcast. In the default build, these equal the stored
                // values.
                out_op_q   <= op_q[sel_idx];
                out_v1_q   <= v1_w[sel_idx];
                out_v2_q   <= v2_w[sel_idx];
                out_imm_q  <= imm_q[sel_idx];
                out_pc_q   <= pc_q[sel_idx];
                out_rob_q  <= rob_q[sel_idx];
                out_pred_q <= pred_q[sel_idx];
            end
        end
    end

    // Entry payload. It needs no reset, because busy_q qualifies every use.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !clr_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (do_issue && (free_idx == IDX_W'(i))) begin
                    op_q[i]   <= issue_op;
                    v1_q[i]   <= iss_v1_w;
                    q1_q[i]   <= iss_q1_w;
                    v2_q[i]   <= iss_v2_w;
                    q2_q[i]   <= iss_q2_w;
                    imm_q[i]  <= issue_imm;
                    pc_q[i]   <= issue_PC;
                    rob_q[i]  <= issue_rob_index;
                    pred_q[i] <= issue_pred_br;
                end else begin
                    v1_q[i] <= v1_w[i];
                    q1_q[i] <= q1_w[i];
                    v2_q[i] <= v2_w[i];
                    q2_q[i] <= q2_w[i];
                end
            end
        end
    end

    assign rs_to_alu_valid     = valid_q;
    assign rs_to_alu_op        = out_op_q;
    assign rs_to_alu_rs1_val   = out_v1_q;
    assign rs_to_alu_rs2_val   = out_v2_q;
    assign rs_to_alu_imm       = out_imm_q;
    assign rs_to_alu_PC        = out_pc_q;
    assign rs_to_alu_rob_index = out_rob_q;
    assign rs_to_alu_pred_br   = out_pred_q;

endmodule

// File: tb/tb_reservation_station.sv
// ---------------------------------------------------------------------------
// tb_reservation_station
//
// This testbench drives the decoder-side issue interface and the two
// broadcast buses of reservation_station. Each expected dispatch is pushed to
// a scoreboard queue when its instruction is issued. A monitor pops the queue
// and compares it against every new dispatch. Hand-written sequences check
// timing, full/flush/freeze/reset behaviour and bus priority.
// ---------------------------------------------------------------------------
module tb_reservation_station;
    localparam int RS_SIZE   = 16;
    localparam int ROB_IDX_W = 4;
    localparam int OPENUM_W  = 6;

    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_ADDI = 6'd9;
    localparam logic [5:0] OP_LUI  = 6'd11;
    localparam logic [5:0] OP_JAL  = 6'd13;
    localparam logic [5:0] OP_BEQ  = 6'd20;

    logic        clk = 1'b0;
    logic        rst_n, rdy, clr;
    logic        issue_rs_ready;
    logic [3:0]  issue_rob_index, issue_rs1_depend, issue_rs2_depend;
    logic [5:0]  issue_op;
    logic [31:0] issue_rs1_val, issue_rs2_val, issue_imm, issue_PC;
    logic        issue_pred_br;
    logic        alu_ready, lsb_ready;
    logic [3:0]  alu_rob_index, lsb_rob_index;
    logic [31:0] alu_result, lsb_result;
    logic        rs_full, rs_to_alu_valid, rs_to_alu_pred_br;
    logic [5:0]  rs_to_alu_op;
    logic [31:0] rs_to_alu_rs1_val, rs_to_alu_rs2_val, rs_to_alu_imm, rs_to_alu_PC;
    logic [3:0]  rs_to_alu_rob_index;

    reservation_station #(
        .RS_SIZE  (RS_SIZE),
        .ROB_IDX_W(ROB_IDX_W),
        .OPENUM_W (OPENUM_W)
    ) dut (
        .clk_in             (clk),
        .rst_n_in           (rst_n),
        .rdy_in             (rdy),
        .clr_in             (clr),
        .issue_rs_ready     (issue_rs_ready),
        .issue_rob_index    (issue_rob_index),
        .issue_op           (issue_op),
        .issue_rs1_val      (issue_rs1_val),
        .issue_rs2_val      (issue_rs2_val),
        .issue_rs1_depend   (issue_rs1_depend),
        .issue_rs2_depend   (issue_rs2_depend),
        .issue_imm          (issue_imm),
        .issue_PC           (issue_PC),
        .issue_pred_br      (issue_pred_br),
        .alu_ready          (alu_ready),
        .alu_rob_index      (alu_rob_index),
        .alu_result         (alu_result),
        .lsb_ready          (lsb_ready),
        .lsb_rob_index      (lsb_rob_index),
        .lsb_result         (lsb_result),
        .rs_full            (rs_full),
        .rs_to_alu_valid    (rs_to_alu_valid),
        .rs_to_alu_op       (rs_to_alu_op),
        .rs_to_alu_rs1_val  (rs_to_alu_rs1_val),
        .rs_to_alu_rs2_val  (rs_to_alu_rs2_val),
        .rs_to_alu_imm      (rs_to_alu_imm),
        .rs_to_alu_PC       (rs_to_alu_PC),
        .rs_to_alu_rob_index(rs_to_alu_rob_index),
        .rs_to_alu_pred_br  (rs_to_alu_pred_br)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] v1, v2, imm, pc;
        logic [3:0]  rob;
        logic        pred;
    } disp_t;

    // Table record: issue inputs, optional same-cycle broadcast
    // (bus: 0 none, 1 alu, 2 lsb) and the operand values that must be
    // dispatched.
    typedef struct {
        logic [5:0]  op;
        logic [31:0] v1;
        logic [3:0]  d1;
        logic [31:0] v2;
        logic [3:0]  d2;
        logic [31:0] imm, pc;
        logic [3:0]  rob;
        logic        pred;
        int          bus;
        logic [3:0]  btag;
        logic [31:0] bval;
        logic [31:0] exp_v1, exp_v2;
    } vec_t;

    disp_t exp_q[$];
    int    n_cmp = 0;
    int    n_fail = 0;
    int    disp_cnt = 0;
    logic  live_edge = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // A dispatch counts as new only when the preceding edge was a live,
    // non-flush edge. While frozen, the outputs merely hold.
    always @(posedge clk) live_edge <= rst_n && rdy && !clr;

    always @(negedge clk) begin
        if (live_edge && rs_to_alu_valid) begin
            disp_t e;
            disp_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_dispatch: got rob %0d, required none (t=%0t)",
                         rs_to_alu_rob_index, $time);
            end else begin
                e = exp_q.pop_front();
                chk("sb_rob",  {28'd0, rs_to_alu_rob_index}, {28'd0, e.rob});
                chk("sb_op",   {26'd0, rs_to_alu_op}, {26'd0, e.op});
                chk("sb_rs1",  rs_to_alu_rs1_val, e.v1);
                chk("sb_rs2",  rs_to_alu_rs2_val, e.v2);
                chk("sb_imm",  rs_to_alu_imm, e.imm);
                chk("sb_pc",   rs_to_alu_PC, e.pc);
                chk("sb_pred", {31'd0, rs_to_alu_pred_br}, {31'd0, e.pred});
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        issue_rs_ready = 1'b0;
        alu_ready      = 1'b0;
        lsb_ready      = 1'b0;
        clr            = 1'b0;
    endtask

    task automatic drive_issue(input logic [5:0] op, input logic [31:0] v1, input logic [3:0] d1,
                               input logic [31:0] v2, input logic [3:0] d2, input logic [31:0] imm,
                               input logic [31:0] pc, input logic [3:0] rob, input logic pred);
        issue_rs_ready   = 1'b1;
        issue_op         = op;
        issue_rs1_val    = v1;
        issue_rs1_depend = d1;
        issue_rs2_val    = v2;
        issue_rs2_depend = d2;
        issue_imm        = imm;
        issue_PC         = pc;
        issue_rob_index  = rob;
        issue_pred_br    = pred;
    endtask

    task automatic push_exp(input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
                            input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] rob,
                            input logic pred);
        disp_t e;
        e.op = op; e.v1 = v1; e.v2 = v2; e.imm = imm; e.pc = pc; e.rob = rob; e.pred = pred;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[7];
        int   dc;

        vecs[0] = '{OP_ADD,  32'h11111111, 4'd0, 32'h22222222, 4'd0, 32'h0,        32'h104, 4'd5,  1'b0, 0, 4'd0, 32'h0,    32'h11111111, 32'h22222222};
        vecs[1] = '{OP_BEQ,  32'hDEAD,     4'd6, 32'h3,        4'd0, 32'hFFFFFFF0, 32'h108, 4'd7,  1'b1, 1, 4'd6, 32'h77,   32'h77,       32'h3};
        vecs[2] = '{OP_ADD,  32'h1,        4'd0, 32'hBEEF,     4'd2, 32'h0,        32'h10C, 4'd8,  1'b0, 2, 4'd2, 32'hCAFE, 32'h1,        32'hCAFE};
        vecs[3] = '{OP_LUI,  32'h0,        4'd0, 32'h0,        4'd0, 32'hABCDE000, 32'h110, 4'd15, 1'b0, 0, 4'd0, 32'h0,    32'h0,        32'h0};
        vecs[4] = '{OP_ADD,  32'h5,        4'd4, 32'h6,        4'd4, 32'h0,        32'h114, 4'd9,  1'b0, 1, 4'd4, 32'h1234, 32'h1234,     32'h1234};
        vecs[5] = '{OP_ADDI, 32'h42,       4'd0, 32'h0,        4'd0, 32'h1,        32'h118, 4'd10, 1'b0, 1, 4'd0, 32'hBAD,  32'h42,       32'h0};
        vecs[6] = '{OP_JAL,  32'h0,        4'd3, 32'h0,        4'd0, 32'h40,       32'h11C, 4'd11, 1'b1, 2, 4'd3, 32'h9,    32'h9,        32'h0};

        rst_n = 1'b0; rdy = 1'b1;
        idle_inputs();
        drive_issue(6'd0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
        issue_rs_ready = 1'b0;
        alu_rob_index = 0; lsb_rob_index = 0; alu_result = 0; lsb_result = 0;
        tick(); tick();
        rst_n = 1'b1;

        // Reset state
        chk("rst_valid", {31'd0, rs_to_alu_valid}, 32'd0);
        chk("rst_full",  {31'd0, rs_full}, 32'd0);
        chk("rst_rob",   {28'd0, rs_to_alu_rob_index}, 32'd0);
        chk("rst_rs1",   rs_to_alu_rs1_val, 32'd0);
        chk("rst_pc",    rs_to_alu_PC, 32'd0);

        // Simple dispatch with the minimum latency
        drive_issue(OP_ADDI, 32'd5, 4'd0, 32'd0, 4'd0, 32'd7, 32'h100, 4'd3, 1'b0);
        push_exp(OP_ADDI, 32'd5, 32'd0, 32'd7, 32'h100, 4'd3, 1'b0);
        tick();
        idle_inputs();
        chk("simple_not_yet", {31'd0, rs_to_alu_valid}, 32'd0);
        tick();
        chk("simple_valid", {31'd0, rs_to_alu_valid}, 32'd1);
        chk("simple_rob",   {28'd0, rs_to_alu_rob_index}, 32'd3);
        chk("simple_rs1",   rs_to_alu_rs1_val, 32'd5);
        chk("simple_imm",   rs_to_alu_imm, 32'd7);
        tick();
        chk("simple_drop", {31'd0, rs_to_alu_valid}, 32'd0);

        // Table: back-to-back issues, some woken by a same-cycle broadcast
        for (int i = 0; i < 7; i++) begin
            drive_issue(vecs[i].op, vecs[i].v1, vecs[i].d1, vecs[i].v2, vecs[i].d2,
                        vecs[i].imm, vecs[i].pc, vecs[i].rob, vecs[i].pred);
            alu_ready = (vecs[i].bus == 1);
            lsb_ready = (vecs[i].bus == 2);
            alu_rob_index = vecs[i].btag; alu_result = vecs[i].bval;
            lsb_rob_index = vecs[i].btag; lsb_result = vecs[i].bval;
            push_exp(vecs[i].op, vecs[i].exp_v1, vecs[i].exp_v2, vecs[i].imm,
                     vecs[i].pc, vecs[i].rob, vecs[i].pred);
            tick();
            if (i > 0) chk("table_stream_valid", {31'd0, rs_to_alu_valid}, 32'd1);
        end
        idle_inputs();
        tick();
        chk("table_last_valid", {31'd0, rs_to_alu_valid}, 32'd1);
        tick();
        chk("table_drain", {31'd0, rs_to_alu_valid}, 32'd0);

        // Wakeup via the ALU bus two cycles after issue
        drive_issue(OP_ADD, 32'h0, 4'd2, 32'd10, 4'd0, 32'h0, 32'h200, 4'd4, 1'b0);
        push_exp(OP_ADD, 32'h55, 32'd10, 32'h0, 32'h200, 4'd4, 1'b0);
        tick();
        idle_inputs();
        chk("wake_pending0", {31'd0, rs_to_alu_valid}, 32'd0);
        tick();
        chk("wake_pending1", {31'd0, rs_to_alu_valid}, 32'd0);
        alu_ready = 1'b1; alu_rob_index = 4'd2; alu_result = 32'h55;
        tick();
        idle_inputs();
`ifdef RS_WAKEUP_BYPASS_EN
        chk("wake_bypass_valid", {31'd0, rs_to_alu_valid}, 32'd1);
        tick();
        chk("wake_bypass_done", {31'd0, rs_to_alu_valid}, 32'd0);
`else
        chk("wake_edge_valid", {31'd0, rs_to_alu_valid}, 32'd0);
        tick();
        chk("wake_disp_valid", {31'd0, rs_to_alu_valid}, 32'd1);
`endif
        tick();

        // ALU and LSB on the same tag: the ALU value wins
        drive_issue(OP_ADD, 32'h0, 4'd5, 32'd2, 4'd0, 32'h0, 32'h300, 4'd10, 1'b0);
        push_exp(OP_ADD, 32'hA, 32'd2, 32'h0, 32'h300, 4'd10, 1'b0);
        tick();
        idle_inputs();
        alu_ready = 1'b1; alu_rob_index = 4'd5; alu_result = 32'hA;
        lsb_ready = 1'b1; lsb_rob_index = 4'd5; lsb_result = 32'hB;
        tick();
        idle_inputs();
        tick(); tick();

        // Freeze: rdy low holds the dispatch outputs and drops issue
        drive_issue(OP_ADDI, 32'd1, 4'd0, 32'd0, 4'd0, 32'd0, 32'h400, 4'd1, 1'b0);
        push_exp(OP_ADDI, 32'd1, 32'd0, 32'd0, 32'h400, 4'd1, 1'b0);
        tick();
        drive_issue(OP_ADDI, 32'd2, 4'd0, 32'd0, 4'd0, 32'd0, 32'h404, 4'd2, 1'b0);
        push_exp(OP_ADDI, 32'd2, 32'd0, 32'd0, 32'h404, 4'd2, 1'b0);
        tick();
        chk("freeze_pre_valid", {31'd0, rs_to_alu_valid}, 32'd1);
        rdy = 1'b0;
        drive_issue(OP_ADDI, 32'd3, 4'd0, 32'd0, 4'd0, 32'd0, 32'h408, 4'd3, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("freeze_valid", {31'd0, rs_to_alu_valid}, 32'd1);
            chk("freeze_rob",   {28'd0, rs_to_alu_rob_index}, 32'd1);
            chk("freeze_pc",    rs_to_alu_PC, 32'h400);
        end
        rdy = 1'b1;
        idle_inputs();
        tick();
        chk("thaw_valid", {31'd0, rs_to_alu_valid}, 32'd1);
        chk("thaw_rob",   {28'd0, rs_to_alu_rob_index}, 32'd2);
        tick();
        chk("thaw_drain", {31'd0, rs_to_alu_valid}, 32'd0);

        // Full: 16 entries waiting on tag 9
        for (int i = 0; i < RS_SIZE; i++) begin
            drive_issue(OP_ADD, 32'h0, 4'd9, 32'(i), 4'd0, 32'h0, 32'h500 + 32'(4 * i), 4'(i), 1'b0);
            push_exp(OP_ADD, 32'd1, 32'(i), 32'h0, 32'h500 + 32'(4 * i), 4'(i), 1'b0);
            tick();
        end
        idle_inputs();
        chk("full_set",   {31'd0, rs_full}, 32'd1);
        chk("full_idle",  {31'd0, rs_to_alu_valid}, 32'd0);
        drive_issue(OP_ADDI, 32'h77, 4'd0, 32'h0, 4'd0, 32'h0, 32'h600, 4'd14, 1'b0);
        tick();
        idle_inputs();
        chk("full_ignore", {31'd0, rs_full}, 32'd1);
        chk("full_ignore_valid", {31'd0, rs_to_alu_valid}, 32'd0);
        lsb_ready = 1'b1; lsb_rob_index = 4'd9; lsb_result = 32'd1;
        tick();
        idle_inputs();
`ifndef RS_WAKEUP_BYPASS_EN
        chk("full_wake_edge", {31'd0, rs_full}, 32'd1);
        tick();
`endif
        for (int k = 0; k < RS_SIZE; k++) begin
            chk("full_burst_valid", {31'd0, rs_to_alu_valid}, 32'd1);
            if (k == 0) chk("full_drop", {31'd0, rs_full}, 32'd0);
            tick();
        end
        chk("full_burst_end", {31'd0, rs_to_alu_valid}, 32'd0);

        // Flush together with an issue and a broadcast
        for (int i = 1; i <= 5; i++) begin
            drive_issue(OP_ADD, 32'h0, 4'd7, 32'h0, 4'd0, 32'h0, 32'h700, 4'(i), 1'b0);
            tick();
        end
        drive_issue(OP_ADDI, 32'h1, 4'd0, 32'h0, 4'd0, 32'h0, 32'h704, 4'd6, 1'b0);
        tick();
        drive_issue(OP_ADDI, 32'h2, 4'd0, 32'h0, 4'd0, 32'h0, 32'h708, 4'd8, 1'b0);
        clr = 1'b1;
        alu_ready = 1'b1; alu_rob_index = 4'd7; alu_result = 32'h33;
        tick();
        idle_inputs();
        chk("flush_valid", {31'd0, rs_to_alu_valid}, 32'd0);
        chk("flush_full",  {31'd0, rs_full}, 32'd0);
        dc = disp_cnt;
        alu_ready = 1'b1; alu_rob_index = 4'd7; alu_result = 32'h33;
        tick();
        idle_inputs();
        for (int k = 0; k < 4; k++) tick();
        chk("flush_no_dispatch", 32'(disp_cnt), 32'(dc));

        // Asynchronous reset while a dispatch is showing
        for (int i = 1; i <= 3; i++) begin
            drive_issue(OP_ADD, 32'h0, 4'd11, 32'h0, 4'd0, 32'h0, 32'h800, 4'(i), 1'b0);
            tick();
        end
        drive_issue(OP_ADDI, 32'h4, 4'd0, 32'h0, 4'd0, 32'h0, 32'h80C, 4'd12, 1'b0);
        push_exp(OP_ADDI, 32'h4, 32'h0, 32'h0, 32'h80C, 4'd12, 1'b0);
        tick();
        idle_inputs();
        tick();
        chk("rstmid_pre_valid", {31'd0, rs_to_alu_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_valid", {31'd0, rs_to_alu_valid}, 32'd0);
        chk("rstmid_full",  {31'd0, rs_full}, 32'd0);
        chk("rstmid_rob",   {28'd0, rs_to_alu_rob_index}, 32'd0);
        tick();
        rst_n = 1'b1;
        drive_issue(OP_ADDI, 32'h9, 4'd0, 32'h0, 4'd0, 32'h3, 32'h900, 4'd13, 1'b1);
        push_exp(OP_ADDI, 32'h9, 32'h0, 32'h3, 32'h900, 4'd13, 1'b1);
        alu_ready = 1'b1; alu_rob_index = 4'd11; alu_result = 32'h66;
        tick();
        idle_inputs();
        tick();
        chk("post_rst_valid", {31'd0, rs_to_alu_valid}, 32'd1);
        chk("post_rst_rob",   {28'd0, rs_to_alu_rob_index}, 32'd13);
        tick();
        chk("post_rst_drain", {31'd0, rs_to_alu_valid}, 32'd0);
        tick(); tick();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Consumer end of the decoder issue interface for ALU-class ops (LUI/AUIPC/JAL/JALR/RC/RI/BR).
- Buffers issued instructions whose operands may be pending on ROB tags.
- Wakes pending operands by snooping ALU and LSB result broadcasts.
- Dispatches one operand-complete entry per cycle to the ALU, and drives rs_full back to the decoder's stall logic.

Parameters:
RS_SIZE, 16, number of entries (power of two, >=2)
ROB_IDX_W, 4, ROB tag width; tag 0 = "no dependency"
OPENUM_W, 6, width of the op enum

Ports:
clk_in  in  1  clock
rst_n_in  in  1  asynchronous active-low reset
rdy_in  in  1  global ready; low freezes all state
clr_in  in  1  mispredict flush, synchronous
issue_rs_ready  in  1  decoder presents an RS instruction this cycle
issue_rob_index  in  ROB_IDX_W  destination ROB tag
issue_op  in  OPENUM_W  op enum
issue_rs1_val / issue_rs2_val  in  32  operand values (valid when matching depend==0)
issue_rs1_depend / issue_rs2_depend  in  ROB_IDX_W  producer tags, 0 = value valid
issue_imm  in  32  immediate
issue_PC  in  32  instruction PC
issue_pred_br  in  1  predicted-taken bit
alu_ready / lsb_ready  in  1  result broadcast valid
alu_rob_index / lsb_rob_index  in  ROB_IDX_W  broadcast tag
alu_result / lsb_result  in  32  broadcast value
rs_full  out  1  no free entry (combinational from registered occupancy only)
rs_to_alu_valid  out  1  dispatch valid, registered
rs_to_alu_op  out  OPENUM_W
rs_to_alu_rs1_val / rs_to_alu_rs2_val / rs_to_alu_imm / rs_to_alu_PC  out  32
rs_to_alu_rob_index  out  ROB_IDX_W
rs_to_alu_pred_br  out  1

Behaviour:
- Reset (rst_n_in low, async): all entries not busy; rs_to_alu_valid=0; all other dispatch outputs 0.
- Entry contents: busy, op, v1, q1, v2, q2, imm, PC, rob, pred.
- Occupancy: rs_full = (busy count == RS_SIZE).
  - rs_full depends only on registered state, so there is no combinational loop through the decoder.
- Priority, evaluated on rising edge:
  - rst_n_in low
  - then clr_in high: every entry not busy, rs_to_alu_valid=0; issue and wakeup that cycle are dropped
  - then rdy_in low: everything holds, including dispatch outputs
  - then normal operation.
- Issue: when issue_rs_ready=1 and not full, write the lowest-index non-busy entry.
  - Issue while rs_full=1 is a protocol violation: ignore it and leave state unchanged.
- Wakeup: for every busy entry and the entry being written this cycle, each operand with q!=0 is checked.
  - If alu_ready and q==alu_rob_index: v<=alu_result, q<=0.
  - Else if lsb_ready and q==lsb_rob_index: v<=lsb_result, q<=0.
  - If both buses match the same tag, ALU wins.
  - Broadcasts with tag 0 are ignored.
- Select: lowest-index busy entry with q1==0 and q2==0, taken from registered state.
  - Dispatch latency: registered outputs load on the edge; that entry's busy clears on the same edge.
  - rs_to_alu_valid=1 for exactly one cycle per dispatched entry; it is 0 when nothing is selectable (other outputs may hold stale values).
- Issue to slot A and dispatch from slot B in the same cycle are independent.
  - A slot freed by dispatch is not reused until the next cycle (issue picks from pre-edge busy bits).
- Minimum latency: issue with all operands ready at edge N, dispatch visible after edge N+1.
- Operand woken at edge N: its entry is selectable for edge N+1.
- No ordering guarantee beyond lowest-index priority; the ROB handles ordering.

Optional Feature:
RS_WAKEUP_BYPASS_EN
- Defined:
  - Select also considers entries whose every pending operand matches a broadcast this cycle.
  - The dispatch register takes the forwarded broadcast value directly.
  - Woken entries can dispatch one cycle earlier (same edge as the wakeup).
  - The entry just being issued is never eligible for bypass dispatch.
- Undefined: selection uses registered q fields only, as in Behaviour.

Test Plan:
- Reset mid-operation: 3 busy entries, drop rst_n_in between edges → rs_to_alu_valid=0 and rs_full=0 immediately; a fresh issue dispatches normally.
- Simple dispatch: issue ADDI (op=ADDI, rs1_val=5, imm=7, depends 0, rob=3) at edge 0 → rs_to_alu_valid=1, rob_index=3, rs1_val=5, imm=7 after edge 1; valid=0 after edge 2.
- Wakeup:
  - Issue ADD with rs1_depend=2, rs2_val=10, rob=4; two cycles later alu_ready=1, alu_rob_index=2, alu_result=0x55 → dispatch after the following edge with rs1_val=0x55, rs2_val=10.
  - With RS_WAKEUP_BYPASS_EN, the same dispatch appears one edge earlier.
- Full: issue 16 entries all dependent on tag 9 → rs_full=1; an extra issue is ignored; lsb_ready with tag 9 and lsb_result=1 → 16 consecutive dispatches in index order, rs_full drops after the first.
- Flush: 5 busy entries, assert clr_in for one cycle together with an issue and a broadcast → all entries cleared, rs_to_alu_valid=0, no later dispatches.
- Freeze and conflict:
  - Hold rdy_in=0 for 4 cycles with a ready entry → no state change.
  - Same-cycle ALU and LSB broadcast on tag 5 (0xA vs 0xB) → operand captures 0xA.
